// File: rtl/proc_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_dbg_pkg
// Description : Shared debug/trace types for the pipeline trace unit.
//               - dbg_state_t : debug controller state (RUN, HALTED, STEP)
//               - dbg_cmd_t   : debug command encoding (RUN, HALT, STEP, CLEAR)
//               - trace_entry_t : one captured retirement in the default
//                 16-bit data / 16-bit pc / 3-bit register configuration
// Revision    : 1.0 - initial release
// ============================================================================
package proc_dbg_pkg;

    // Default field widths of a trace entry; the trace unit parameters
    // default to these values.
    localparam int C_DATA_W = 16;
    localparam int C_PC_W   = 16;
    localparam int C_RF_AW  = 3;

    // Encodings are externally visible on dbg_state / cmd_op.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } dbg_state_t;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_HALT  = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_CLEAR = 2'd3
    } dbg_cmd_t;

    // Field order matches the flat packing used inside the trace unit:
    // {pc, addr, data, carry, zero}.
    typedef struct packed {
        logic [C_PC_W-1:0]   pc;
        logic [C_RF_AW-1:0]  addr;
        logic [C_DATA_W-1:0] data;
        logic                carry;
        logic                zero;
    } trace_entry_t;

endpackage : proc_dbg_pkg
`default_nettype wire

// File: rtl/trace_ring_buf.sv
`default_nettype none
// ============================================================================
// Module      : trace_ring_buf
// Description : Circular buffer with overwrite-on-full, first-word-fall-through
//               output, occupancy count and sticky overflow flag.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-low reset
//               clear      - synchronous flush (drops same-cycle push/pop)
//               push       - write push_data this cycle
//               push_data  - entry to store
//               rd_ready   - consumer pops the head when rd_valid is high
//               rd_valid   - registered, buffer not empty
//               rd_data    - head entry (zero when empty)
//               count      - entries held, 0..DEPTH
//               overflow   - sticky, an entry was overwritten while full
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ring_buf #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0]   c_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_valid;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_overflow_nxt;

    // A flush wins over any traffic in the same cycle.
    assign w_push = push & ~clear;
    assign w_pop  = r_valid & rd_ready & ~clear;
    assign w_full = (r_count == c_FULL);

    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        if (clear) begin
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            // Full with nobody draining: the oldest entry is sacrificed so
            // the most recent history is kept.
            w_wr_ptr_nxt   = r_wr_ptr + c_PTR_ONE;
            w_rd_ptr_nxt   = r_rd_ptr + c_PTR_ONE;
            w_overflow_nxt = 1'b1;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_valid    <= (w_count_nxt != '0);
        end
    end

    // Storage carries no reset; stale contents are masked by r_valid below.
    // When full, a push lands in the slot being popped, which is safe because
    // the head is read combinationally before the edge.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_valid ? r_mem[r_rd_ptr] : '0;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule : trace_ring_buf
`default_nettype wire

// File: rtl/pipe_trace_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_unit
// Description : Write-back snooping trace unit. Captures every retired
//               register write into a circular trace buffer and provides
//               PC breakpoint, halt and single-step control of the core.
// Ports       : clk, reset (async active-low)
//               wb_valid/wb_pc/wb_addr/wb_data/wb_carry/wb_zero - retirement
//               bp_en/bp_pc         - breakpoint enable and address
//               cmd_valid/cmd_op    - debug command (RUN/HALT/STEP/CLEAR)
//               cmd_ready           - command accepted when both high
//               halt_req            - fetch/decode stall to the core
//               rd_valid/rd_ready   - trace read handshake (FWFT)
//               rd_pc/rd_addr/rd_data/rd_flags - oldest entry ({carry,zero})
//               count, overflow     - occupancy and sticky loss flag
//               dbg_state           - 0 RUN, 1 HALTED, 2 STEP
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_unit
    import proc_dbg_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int PC_W   = C_PC_W,
    parameter int RF_AW  = C_RF_AW,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [RF_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_carry,
    input  logic              wb_zero,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_pc,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    output logic              halt_req,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PC_W-1:0]   rd_pc,
    output logic [RF_AW-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_flags,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    localparam int c_ENTRY_W = PC_W + RF_AW + DATA_W + 2;

    dbg_state_t r_state;
    logic       r_halt_req;
    logic       r_cmd_ready;

    dbg_cmd_t             w_cmd;
    logic                 w_cmd_fire;
    logic                 w_clear;
    logic                 w_bp_hit;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_rd_entry;

    assign w_cmd      = dbg_cmd_t'(cmd_op);
    assign w_cmd_fire = cmd_valid & r_cmd_ready;
    assign w_clear    = w_cmd_fire & (w_cmd == CMD_CLEAR);
    assign w_bp_hit   = wb_valid & bp_en & (wb_pc == bp_pc);

    // Same layout as trace_entry_t: {pc, addr, data, carry, zero}.
    assign w_push_entry = {wb_pc, wb_addr, wb_data, wb_carry, wb_zero};

    trace_ring_buf #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .push      (wb_valid),
        .push_data (w_push_entry),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (w_rd_entry),
        .count     (count),
        .overflow  (overflow)
    );

    assign rd_pc    = w_rd_entry[c_ENTRY_W-1 -: PC_W];
    assign rd_addr  = w_rd_entry[DATA_W+2 +: RF_AW];
    assign rd_data  = w_rd_entry[2 +: DATA_W];
    assign rd_flags = w_rd_entry[1:0];

    // Debug controller. halt_req and cmd_ready are registered alongside the
    // state so they change exactly on the state transition.
    // CLEAR never changes state; it only reaches the buffer via w_clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_halt_req  <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A breakpoint outranks a coincident RUN command.
                    if (w_bp_hit || (w_cmd_fire && w_cmd == CMD_HALT)) begin
                        r_state     <= ST_HALTED;
                        r_halt_req  <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (w_cmd_fire && w_cmd == CMD_RUN) begin
                        r_state     <= ST_RUN;
                        r_halt_req  <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else if (w_cmd_fire && w_cmd == CMD_STEP) begin
                        r_state     <= ST_STEP;
                        r_halt_req  <= 1'b0;
                        r_cmd_ready <= 1'b0;
                    end
                end
                ST_STEP: begin
                    // The first retirement completes the step; a breakpoint
                    // can only occur on a retirement, so it lands here too.
                    if (wb_valid) begin
                        r_state     <= ST_HALTED;
                        r_halt_req  <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_halt_req  <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign halt_req  = r_halt_req;
    assign cmd_ready = r_cmd_ready;
    assign dbg_state = r_state;

endmodule : pipe_trace_unit
`default_nettype wire

// File: tb/tb_pipe_trace_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_trace_unit
// Description : Self-checking bench for pipe_trace_unit. A queue-based model
//               tracks the trace contents and debug state; every negative
//               clock edge the DUT outputs are compared against it. Directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_trace_unit;
    import proc_dbg_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [15:0] wb_pc;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_carry;
    logic        wb_zero;
    logic        bp_en;
    logic [15:0] bp_pc;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        halt_req;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_pc;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  rd_flags;
    logic [PTR_W:0] count;
    logic        overflow;
    logic [1:0]  dbg_state;

    pipe_trace_unit #(
        .DATA_W (16),
        .PC_W   (16),
        .RF_AW  (3),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_carry  (wb_carry),
        .wb_zero   (wb_zero),
        .bp_en     (bp_en),
        .bp_pc     (bp_pc),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .halt_req  (halt_req),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_pc     (rd_pc),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_flags  (rd_flags),
        .count     (count),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- behavioural model ----------------
    trace_entry_t m_q[$];
    bit           m_ovf;
    int           m_state;   // 0 running, 1 halted, 2 stepping

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_state = 0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit fire, clr, pop, bp;
        trace_entry_t e;
        if (!reset) begin
            model_reset();
            return;
        end
        fire = cmd_valid && (m_state != 2);
        clr  = fire && (cmd_op == 2'd3);
        pop  = (m_q.size() != 0) && rd_ready;
        bp   = wb_valid && bp_en && (wb_pc == bp_pc);
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) m_q.delete(0);
            if (wb_valid) begin
                e.pc = wb_pc; e.addr = wb_addr; e.data = wb_data;
                e.carry = wb_carry; e.zero = wb_zero;
                m_q.push_back(e);
            end
            if (m_q.size() > DEPTH) begin
                m_q.delete(0);
                m_ovf = 1'b1;
            end
        end
        case (m_state)
            0: if (bp || (fire && cmd_op == 2'd1)) m_state = 1;
            1: if (fire && cmd_op == 2'd0) m_state = 0;
               else if (fire && cmd_op == 2'd2) m_state = 2;
            default: if (wb_valid) m_state = 1;
        endcase
    endtask

    // Compare process: outputs are all registered, so negedge is stable.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count",     32'(count),     32'(m_q.size()));
            check("rd_valid",  32'(rd_valid),  32'(m_q.size() != 0));
            check("overflow",  32'(overflow),  32'(m_ovf));
            check("dbg_state", 32'(dbg_state), 32'(m_state));
            check("halt_req",  32'(halt_req),  32'(m_state == 1));
            check("cmd_ready", 32'(cmd_ready), 32'(m_state != 2));
            if (m_q.size() != 0) begin
                check("rd_pc",    32'(rd_pc),    32'(m_q[0].pc));
                check("rd_addr",  32'(rd_addr),  32'(m_q[0].addr));
                check("rd_data",  32'(rd_data),  32'(m_q[0].data));
                check("rd_flags", 32'(rd_flags), 32'({m_q[0].carry, m_q[0].zero}));
            end else begin
                check("rd_pc_empty",   32'(rd_pc),   32'h0);
                check("rd_data_empty", 32'(rd_data), 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [15:0] pc, input logic [2:0] a, input logic [15:0] d,
                          input logic c, input logic z);
        wb_valid = 1'b1; wb_pc = pc; wb_addr = a; wb_data = d; wb_carry = c; wb_zero = z;
    endtask

    task automatic cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cyc();
        cmd_valid = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; wb_valid = 0; wb_pc = 0; wb_addr = 0; wb_data = 0;
        wb_carry = 0; wb_zero = 0; bp_en = 0; bp_pc = 0; cmd_valid = 0;
        cmd_op = 0; rd_ready = 0;
        #2;
        reset = 1'b0;
        model_reset();
        @(negedge clk); #1;
        chk_en = 1'b1;
        check("rst_rd_valid",  32'(rd_valid),  32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_halt_req",  32'(halt_req),  32'h0);
        reset = 1'b1;
        cyc();

        // S1: three pushes, no reads
        set_wb(16'h0001, 3'd1, 16'h00AA, 1'b0, 1'b1); cyc();
        set_wb(16'h0002, 3'd2, 16'h00BB, 1'b1, 1'b0); cyc();
        set_wb(16'h0003, 3'd3, 16'h00CC, 1'b1, 1'b1); cyc();
        wb_valid = 1'b0;
        check("s1_count",   32'(count),    32'd3);
        check("s1_valid",   32'(rd_valid), 32'd1);
        check("s1_pc",      32'(rd_pc),    32'h0001);
        check("s1_data",    32'(rd_data),  32'h00AA);
        check("s1_ovf",     32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("s1_drain_pc", 32'(rd_pc), 32'(i + 1));
            cyc();
        end
        cyc();                          // empty with rd_ready high: no pop
        check("s1_empty_cnt", 32'(count), 32'd0);
        rd_ready = 1'b0;

        // S2: 18 pushes into 16 entries
        for (int i = 0; i < 18; i++) begin
            set_wb(16'h0100 + 16'(i), 3'(i), 16'(i), 1'b0, 1'b0);
            cyc();
        end
        wb_valid = 1'b0;
        check("s2_count", 32'(count),    32'd16);
        check("s2_ovf",   32'(overflow), 32'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("s2_drain", 32'(rd_data), 32'(i + 2));
            cyc();
        end
        rd_ready = 1'b0;
        check("s2_count_end", 32'(count), 32'd0);

        // S3: breakpoint on 0x0005 in a back-to-back run
        bp_en = 1'b1; bp_pc = 16'h0005;
        set_wb(16'h0004, 3'd4, 16'h0044, 1'b0, 1'b0); cyc();
        check("s3_run_before", 32'(halt_req), 32'd0);
        set_wb(16'h0005, 3'd5, 16'h0055, 1'b0, 1'b0); cyc();
        check("s3_halt_req", 32'(halt_req),  32'd1);
        check("s3_state",    32'(dbg_state), 32'd1);
        set_wb(16'h0006, 3'd6, 16'h0066, 1'b0, 1'b0); cyc();
        wb_valid = 1'b0;
        bp_en = 1'b0;
        check("s3_count", 32'(count), 32'd3);

        // S4: single step; a command during the step is refused
        cmd(2'd2);
        check("s4_step_halt", 32'(halt_req),  32'd0);
        check("s4_step_rdy",  32'(cmd_ready), 32'd0);
        check("s4_step_st",   32'(dbg_state), 32'd2);
        cmd_valid = 1'b1; cmd_op = 2'd3; cyc(); cmd_valid = 1'b0;
        check("s4_clr_refused", 32'(count), 32'd3);
        set_wb(16'h0007, 3'd7, 16'h0077, 1'b1, 1'b0); cyc();
        wb_valid = 1'b0;
        check("s4_rehalt",   32'(halt_req),  32'd1);
        check("s4_state",    32'(dbg_state), 32'd1);
        check("s4_count",    32'(count),     32'd4);
        cmd(2'd1);                      // HALT while halted: no-op
        cmd(2'd0);                      // RUN
        check("s4_run", 32'(dbg_state), 32'd0);
        cmd(2'd2);                      // STEP while running: no-op
        cmd(2'd0);                      // RUN while running: no-op
        check("s4_still_run", 32'(dbg_state), 32'd0);
        cmd(2'd3);                      // CLEAR
        check("s4_cleared_ovf", 32'(overflow), 32'd0);

        // S5: full buffer, simultaneous push and pop for 5 cycles
        for (int i = 0; i < 16; i++) begin
            set_wb(16'h0200 + 16'(i), 3'(i), 16'h0200 + 16'(i), 1'b0, 1'b1);
            cyc();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("s5_pop_order", 32'(rd_data), 32'(16'h0200 + i));
            set_wb(16'h0300 + 16'(i), 3'(i), 16'h0300 + 16'(i), 1'b1, 1'b0);
            cyc();
        end
        rd_ready = 1'b0;
        wb_valid = 1'b0;
        check("s5_count", 32'(count),    32'd16);
        check("s5_ovf",   32'(overflow), 32'd0);
        set_wb(16'h0400, 3'd0, 16'h0400, 1'b0, 1'b0); cyc();   // lose one
        wb_valid = 1'b0;
        check("s5_ovf_set", 32'(overflow), 32'd1);

        // S6: CLEAR with a coincident push and pop, then reset mid-step
        cmd(2'd3);
        for (int i = 0; i < 7; i++) begin
            set_wb(16'h0500 + 16'(i), 3'(i), 16'(i), 1'b0, 1'b0);
            cyc();
        end
        check("s6_seven", 32'(count), 32'd7);
        set_wb(16'h0600, 3'd1, 16'h0600, 1'b0, 1'b0);
        rd_ready = 1'b1;
        cmd(2'd3);
        wb_valid = 1'b0; rd_ready = 1'b0;
        check("s6_clr_count", 32'(count),    32'd0);
        check("s6_clr_ovf",   32'(overflow), 32'd0);

        // Breakpoint coinciding with a RUN command in RUN: breakpoint wins
        bp_en = 1'b1; bp_pc = 16'h0050;
        set_wb(16'h0050, 3'd2, 16'h1234, 1'b0, 1'b1);
        cmd(2'd0);
        wb_valid = 1'b0; bp_en = 1'b0;
        check("s6_bp_vs_run", 32'(dbg_state), 32'd1);
        set_wb(16'h0051, 3'd3, 16'h2345, 1'b1, 1'b1); cyc();   // in-flight retire
        wb_valid = 1'b0;
        cmd(2'd2);
        cyc();
        check("s6_in_step", 32'(dbg_state), 32'd2);
        reset = 1'b0;
        model_reset();
        cyc();
        check("s6_rst_state", 32'(dbg_state), 32'd0);
        check("s6_rst_halt",  32'(halt_req),  32'd0);
        check("s6_rst_valid", 32'(rd_valid),  32'd0);
        check("s6_rst_pc",    32'(rd_pc),     32'd0);
        check("s6_rst_addr",  32'(rd_addr),   32'd0);
        check("s6_rst_data",  32'(rd_data),   32'd0);
        check("s6_rst_flags", 32'(rd_flags),  32'd0);
        check("s6_rst_count", 32'(count),     32'd0);
        reset = 1'b1;
        cyc();
        set_wb(16'h0700, 3'd4, 16'h0777, 1'b1, 1'b1); cyc();
        wb_valid = 1'b0;
        check("s6_after_rst", 32'(rd_pc), 32'h0700);
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_trace_unit
`default_nettype wire

// File: doc/pipe_trace_unit.md
Name: pipe_trace_unit

Overview:
- Parametrised debug/trace successor to the processor's flat per-signal debug outputs.
- Sits beside the core and snoops the write-back stage.
- Captures each retired register write (pc, dest, data, flags) into a circular trace buffer, with PC breakpoint, halt and single-step control.
- Trace is drained through a valid/ready read port. halt_req drives the core's fetch/decode stall.

Parameters:
- DATA_W, 16: register/data width.
- PC_W, 16: program counter width.
- RF_AW, 3: register-file address width.
- DEPTH, 16: trace entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH): buffer pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  write-back retiring a register write this cycle.
- wb_pc  in  PC_W  pc of the retiring instruction.
- wb_addr  in  RF_AW  destination register.
- wb_data  in  DATA_W  write data.
- wb_carry  in  1  carry flag after the instruction.
- wb_zero  in  1  zero flag after the instruction.
- bp_en  in  1  breakpoint enable.
- bp_pc  in  PC_W  breakpoint pc.
- cmd_valid  in  1  debug command strobe.
- cmd_op  in  2  command: 0 RUN, 1 HALT, 2 STEP, 3 CLEAR.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- halt_req  out  1  stall request to the core.
- rd_valid  out  1  trace entry available.
- rd_ready  in  1  consumer pops the entry.
- rd_pc  out  PC_W  oldest entry pc.
- rd_addr  out  RF_AW  oldest entry destination.
- rd_data  out  DATA_W  oldest entry data.
- rd_flags  out  2  oldest entry flags, {carry, zero}.
- count  out  PTR_W+1  number of entries held.
- overflow  out  1  sticky: at least one entry was lost.
- dbg_state  out  2  0 RUN, 1 HALTED, 2 STEP.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to RUN. Pointers, count and overflow clear.
  - halt_req=0, rd_valid=0, cmd_ready=1.
  - rd_pc/rd_addr/rd_data/rd_flags read 0. Buffer contents are don't-care.
- Reset asserted mid-step or mid-readout aborts immediately. No entry is preserved.
- Capture:
  - Every cycle with wb_valid=1 pushes {wb_pc, wb_addr, wb_data, wb_carry, wb_zero}, in any state.
  - Instructions in flight during a halt still retire and are captured.
- Read port:
  - First-word-fall-through. rd_* show the entry at the read pointer.
  - rd_valid = (count != 0), registered.
  - An entry pushed in cycle N is visible on rd_* in cycle N+1.
  - Pop occurs when rd_valid and rd_ready are both high.
- Buffer boundary cases:
  - Empty with rd_ready=1: no pop, count stays 0.
  - Push and pop in the same cycle while not full: count unchanged.
  - Full, push, no pop: overwrite the oldest entry, advance both pointers, count stays DEPTH, overflow set to 1.
  - Full, push and pop together: normal operation, count stays DEPTH, no overflow.
  - Pointers wrap modulo DEPTH.
- Breakpoint:
  - Fires when wb_valid=1, bp_en=1 and wb_pc==bp_pc.
  - The matching entry is still captured.
  - In RUN or STEP, state becomes HALTED next cycle, and halt_req=1 from that cycle.
- FSM (halt_req is registered: 0 in RUN, 1 in HALTED, 0 in STEP):
  - RUN: HALT command goes to HALTED. A breakpoint goes to HALTED.
  - HALTED: RUN command goes to RUN. STEP command goes to STEP.
  - STEP: the first subsequent wb_valid is captured, then state returns to HALTED. halt_req is reasserted the cycle after that retirement.
  - STEP: cmd_ready=0, so commands are not accepted until step completes. cmd_ready=1 in every other state.
  - Commands that are illegal in the current state (HALT in HALTED, STEP in RUN, RUN in RUN) are accepted and are no-ops.
- CLEAR command:
  - Empties the buffer next cycle and clears overflow. State is unchanged.
  - A push in the same cycle as CLEAR is discarded. After CLEAR, count=0.
  - A pop in the same cycle as CLEAR is ignored.
- Simultaneous breakpoint and RUN command in RUN: the breakpoint wins, state goes to HALTED.
- Simultaneous breakpoint and HALT command: state goes to HALTED.
- Width rules: count is PTR_W+1 bits so that DEPTH is representable. The pc compare is full-width equality.

Decomposition:
- Shared package proc_dbg_pkg holds:
  - dbg_state_t enum: RUN, HALTED, STEP.
  - dbg_cmd_t enum: RUN, HALT, STEP, CLEAR.
  - trace_entry_t struct: pc, addr, data, carry, zero.
- One natural sub-module, trace_ring_buf: a parametrised circular buffer with overwrite-on-full, FWFT output, count and overflow.
- The FSM and breakpoint compare stay in pipe_trace_unit.

Test Plan:
- Reset, then 3 pushes: pc 0x0001/0x0002/0x0003, addr 1/2/3, data 0x00AA/0x00BB/0x00CC, rd_ready=0 → count=3, rd_valid=1, rd_pc=0x0001, rd_data=0x00AA, overflow=0.
- DEPTH=16: 18 pushes with data 0..17, no pops → count=16, overflow=1; drained sequence is 2..17.
- bp_en=1, bp_pc=0x0005, retire pcs 0x0004, 0x0005, 0x0006 back-to-back → halt_req=1 the cycle after 0x0005 retires; all three entries captured; dbg_state=HALTED.
- From HALTED, issue STEP; retire pc 0x0007 two cycles later → halt_req=0 during the step, cmd_ready=0; back to HALTED and halt_req=1 the cycle after; entry 0x0007 captured.
- Buffer full with rd_ready=1 and wb_valid=1 for 5 cycles → count stays 16, overflow stays 0, 5 oldest entries popped in order.
- CLEAR with 7 entries and a coincident push, then reset=0 asserted mid-STEP → count=0, overflow=0 after CLEAR; after reset, dbg_state=RUN, halt_req=0, rd_valid=0, all rd_* read 0.
